// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative unsigned multiply/divide unit.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_div(input logic [1:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration over the {hi,lo} pair: shift-add for multiply,
// restoring compare-subtract-shift for divide.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             ge;

  always_comb begin
    addend = lo_i[0] ? b_i : '0;
    sum    = {1'b0, hi_i} + {1'b0, addend};
    // Shifted remainder is WIDTH+1 bits; its top bit alone guarantees rem >= divisor.
    diff   = {1'b0, hi_i[WIDTH-2:0], lo_i[WIDTH-1]} - {1'b0, b_i};
    ge     = hi_i[WIDTH-1] | ~diff[WIDTH];
    if (is_div_i) begin
      hi_o = ge ? diff[WIDTH-1:0] : {hi_i[WIDTH-2:0], lo_i[WIDTH-1]};
      lo_o = {lo_i[WIDTH-2:0], ge};
    end else begin
      hi_o = sum[WIDTH:1];
      lo_o = {sum[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// EX-stage iterative MUL/MULHU/DIVU/REMU sequencer; holds the pipeline via Stall.
// Optional MULDIV_FAST_ZERO_EN: zero operands skip the iteration phase.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Stall
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d;      // product high / remainder
  logic [WIDTH-1:0] lo_q, lo_d;      // product low (multiplier) / quotient
  logic [WIDTH-1:0] b_q, b_d;        // multiplicand / divisor
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] step_hi, step_lo, sel;
  logic             accept;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div(op_q)),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .b_i      (b_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  assign accept = (state_q == ST_IDLE) & Start & ~Flush;

  always_comb begin
    case (op_q)
      OP_MUL, OP_DIVU: sel = lo_q;
      default:         sel = hi_q;
    endcase
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = Op;
          cnt_d   = CNT_W'(WIDTH);
          hi_d    = '0;
          lo_d    = is_div(Op) ? SrcA : SrcB;
          b_d     = is_div(Op) ? SrcB : SrcA;
          state_d = ST_BUSY;
`ifdef MULDIV_FAST_ZERO_EN
          if ((SrcA == '0) || (SrcB == '0)) begin
            // Load the finished {hi,lo} layout directly so the result mux is unchanged.
            state_d = ST_DONE;
            cnt_d   = '0;
            lo_d    = (is_div(Op) && (SrcB == '0)) ? '1 : '0;
            hi_d    = (is_div(Op) && (SrcB == '0)) ? SrcA : '0;
          end
`endif
        end
      end
      ST_BUSY: begin
        if (Flush) begin
          state_d = ST_IDLE;
        end else begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (!Flush) result_d = sel;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments; the datapath registers are reset too
  // so no output can ever show X after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  // The live result is shown in the Done cycle; result_q commits it only if not flushed.
  assign Busy   = (state_q == ST_BUSY);
  assign Done   = (state_q == ST_DONE) & ~Flush;
  assign Stall  = accept | (Busy & ~Flush);
  assign Result = Done ? sel : result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: arithmetic reference model with a
// per-cycle compare, directed literal cases, random traffic, flush and reset.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          Start;
  logic [1:0]    Op;
  logic [W-1:0]  SrcA, SrcB;
  logic          Flush;
  logic          Busy, Done, Stall;
  logic [W-1:0]  Result;

  int checks   = 0;
  int failures = 0;

  muldiv_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .Start  (Start),
    .Op     (Op),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .Flush  (Flush),
    .Busy   (Busy),
    .Done   (Done),
    .Result (Result),
    .Stall  (Stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      OP_MUL:   return p[31:0];
      OP_MULHU: return p[63:32];
      OP_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default:  return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit fast_zero(input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FAST_ZERO_EN
    return (a == 0) || (b == 0);
`else
    return (a == 0) && (b == 0) && 1'b0;
`endif
  endfunction

  // Reference model: phase 0 idle, 1 iterating (m_left cycles to go), 2 result cycle.
  int           m_phase, m_left;
  logic [31:0]  m_pending, m_held;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase   <= 0;
      m_left    <= 0;
      m_pending <= '0;
      m_held    <= '0;
    end else begin
      case (m_phase)
        0: if (Start && !Flush) begin
          m_pending <= ref_result(Op, SrcA, SrcB);
          if (fast_zero(SrcA, SrcB)) m_phase <= 2;
          else begin
            m_phase <= 1;
            m_left  <= W;
          end
        end
        1: if (Flush) m_phase <= 0;
           else begin
             m_left <= m_left - 1;
             if (m_left == 1) m_phase <= 2;
           end
        default: begin
          if (!Flush) m_held <= m_pending;
          m_phase <= 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    check("busy",  32'(Busy),  32'(m_phase == 1));
    check("done",  32'(Done),  32'(m_phase == 2 && !Flush));
    check("stall", 32'(Stall), 32'((((m_phase == 0) && Start) || (m_phase == 1)) && !Flush));
    check("result", Result, (m_phase == 2 && !Flush) ? m_pending : m_held);
  end

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res);
    int          cyc, stall_n, busy_n;
    bit          seen, fz;
    logic [31:0] res;
    fz      = fast_zero(a, b);
    seen    = 0;
    cyc     = 0;
    stall_n = 0;
    busy_n  = 0;
    res     = '0;
    @(posedge clk); #1;
    Start = 1'b1; Op = op; SrcA = a; SrcB = b;
    for (int c = 1; c <= 100 && !seen; c++) begin
      @(negedge clk);
      cyc = c;
      if (Stall) stall_n++;
      if (Busy)  busy_n++;
      if (Done) begin
        seen = 1;
        res  = Result;
      end else begin
        @(posedge clk); #1;
        Start = 1'b0;
      end
    end
    Start = 1'b0;
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_result"}, res, exp_res);
    check({name, "_done_cycle"}, 32'(cyc), fz ? 32'd2 : 32'd34);
    check({name, "_stall_cycles"}, 32'(stall_n), fz ? 32'd1 : 32'd33);
    check({name, "_busy_cycles"}, 32'(busy_n), fz ? 32'd0 : 32'd32);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom % 4)
      0:       return '0;
      1:       return 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; Start = 1'b0; Op = OP_MUL; SrcA = '0; SrcB = '0; Flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",   32'(Busy),  32'd0);
    check("rst_done",   32'(Done),  32'd0);
    check("rst_stall",  32'(Stall), 32'd0);
    check("rst_result", Result,     32'd0);
    reset = 1'b0;

    run_op("mul_7x6",    OP_MUL,   32'd7,         32'd6,         32'h0000_002A);
    run_op("mulhu_ff",   OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mul_ff",     OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op("divu_100_7", OP_DIVU,  32'd100,       32'd7,         32'h0000_000E);
    run_op("remu_100_7", OP_REMU,  32'd100,       32'd7,         32'h0000_0002);
    run_op("divu_5_0",   OP_DIVU,  32'd5,         32'd0,         32'hFFFF_FFFF);
    run_op("remu_5_0",   OP_REMU,  32'd5,         32'd0,         32'h0000_0005);

    // Flush in the 10th iterating cycle.
    @(posedge clk); #1;
    Start = 1'b1; Op = OP_MUL; SrcA = 32'd3; SrcB = 32'd5;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    Flush = 1'b1;
    #1;
    check("flush_stall_same_cycle", 32'(Stall), 32'd0);
    check("flush_busy_same_cycle",  32'(Busy),  32'd1);
    @(posedge clk); #1;
    Flush = 1'b0;
    check("flush_busy_after",  32'(Busy),  32'd0);
    check("flush_done_after",  32'(Done),  32'd0);
    check("flush_stall_after", 32'(Stall), 32'd0);
    check("flush_result_kept", Result,     32'h0000_0005);
    repeat (40) @(posedge clk);
    run_op("mul_after_flush", OP_MUL, 32'd3, 32'd5, 32'h0000_000F);

    // Random traffic: Start/Flush at any time, operands biased toward 0 and small values.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      Start = ($urandom % 3) != 0;
      Op    = 2'($urandom % 4);
      SrcA  = rand_operand();
      SrcB  = rand_operand();
      Flush = ($urandom % 100) == 0;
    end
    @(posedge clk); #1;
    Start = 1'b0; Flush = 1'b0;
    repeat (40) @(posedge clk);

    // Asynchronous reset in the middle of an operation.
    run_op("mul_pre_reset", OP_MUL, 32'd7, 32'd6, 32'h0000_002A);
    @(posedge clk); #1;
    Start = 1'b1; Op = OP_DIVU; SrcA = 32'd1000; SrcB = 32'd3;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("arst_busy",   32'(Busy),  32'd0);
    check("arst_done",   32'(Done),  32'd0);
    check("arst_stall",  32'(Stall), 32'd0);
    check("arst_result", Result,     32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_op("divu_after_reset", OP_DIVU, 32'd1000, 32'd3, 32'd333);

`ifdef MULDIV_FAST_ZERO_EN
    run_op("fz_mul_0x9",  OP_MUL,  32'd0, 32'd9, 32'd0);
    run_op("fz_divu_0_9", OP_DIVU, 32'd0, 32'd9, 32'd0);
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
